led_matrix_scan_driver: RTL and testbench

Downstream consumer of the game engine's eight 8-bit display rows. Snapshots the full frame once per scan and multiplexes it row by row onto an 8x8 LED matrix. The matrix is driven through two daisy-chained 74HC595 shift registers. While the engine asserts end-of-game, the driver blinks the whole display.

---
 rtl/led_matrix_scan_driver.sv | 201 ++++++++++++++++++++
 tb/tb_led_matrix_scan_driver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_driver.sv
// -----------------------------------------------------------------------------
// led_matrix_scan_driver
//
// Takes the game engine's 8x8 display frame and scans it row by row onto an
// LED matrix. The matrix hangs off two daisy-chained 74HC595 shift registers.
// The serial word for each row is {rowSel, colBits}, shifted out MSB first.
// The column byte is active-low (cathode drive).
//
// At every row-0 load the whole frame is snapshotted, so that a scan never
// shows a torn image. While the engine holds eog high, the display blinks:
// it is lit for BLINK_FRAMES frames, then dark for BLINK_FRAMES frames, and
// so on.
//
// Ports
//   clk        system clock, rising edge
//   rstBtn     synchronous active-high reset
//   frame      64-bit display; frame[8*r+7:8*r] is row r, bit 7 = left column
//   eog        end-of-game level, sampled at the row-0 load
//   serData    595 serial data
//   serClk     595 shift clock
//   serLatch   595 storage latch pulse (CLK_DIV cycles wide)
//   outEn_n    595 output enable, low once the first row has been latched
//   rowIdx     row being loaded / lit
//   frameDone  high during the final HOLD cycle of row 7
// -----------------------------------------------------------------------------
module led_matrix_scan_driver #(
    parameter int CLK_DIV      = 4,
    parameter int ROW_HOLD     = 2000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rstBtn,
    input  logic [63:0] frame,
    input  logic        eog,
    output logic        serData,
    output logic        serClk,
    output logic        serLatch,
    output logic        outEn_n,
    output logic [2:0]  rowIdx,
    output logic        frameDone
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W  = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ROW_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_PRE  = HOLD_W'((ROW_HOLD > 1) ? ROW_HOLD - 2 : 0);
    localparam logic               HOLD_ONE  = (ROW_HOLD == 1);
    localparam logic [BLINK_W-1:0] BLINK_END = BLINK_W'(BLINK_FRAMES);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q;
    logic [2:0]          row_q;
    logic [63:0]         snap_q;
    logic                blink_q;
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic [15:0]         shreg_q;
    logic [3:0]          bit_q;
    logic [DIV_W-1:0]    div_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                ser_data_q;
    logic                ser_clk_q;
    logic                ser_latch_q;
    logic                out_en_n_q;
    logic                frame_done_q;

    logic [63:0]         snap_d;
    logic                blink_d;
    logic [BLINK_W-1:0]  blink_cnt_d;
    logic [7:0]          row_byte_d;
    logic [7:0]          row_sel_d;
    logic [7:0]          col_bits_d;
    logic [15:0]         word_d;

    // Row-load values: new snapshot and blink phase at row 0, then the serial word.
    always_comb begin
        snap_d      = snap_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (row_q == 3'd0) begin
            // Same-edge capture: row 0 is built from the live frame input.
            snap_d = frame;
            if (eog) begin
                // The counter holds the number of frames already shown in the
                // current phase; a full phase flips blinkOn for this new frame.
                if (blink_cnt_q == BLINK_END) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = BLINK_W'(1);
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end else begin
                blink_d     = 1'b1;
                blink_cnt_d = {BLINK_W{1'b0}};
            end
        end else begin
            snap_d = snap_q;
        end
        row_byte_d = snap_d[{row_q, 3'b000} +: 8];
        row_sel_d  = 8'd1 << row_q;
        col_bits_d = blink_d ? ~row_byte_d : 8'hFF;
        word_d     = {row_sel_d, col_bits_d};
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rstBtn) begin
            state_q      <= ST_LOAD;
            row_q        <= 3'd0;
            snap_q       <= 64'd0;
            blink_q      <= 1'b1;
            blink_cnt_q  <= {BLINK_W{1'b0}};
            shreg_q      <= 16'd0;
            bit_q        <= 4'd0;
            div_q        <= {DIV_W{1'b0}};
            hold_q       <= {HOLD_W{1'b0}};
            ser_data_q   <= 1'b0;
            ser_clk_q    <= 1'b0;
            ser_latch_q  <= 1'b0;
            out_en_n_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    snap_q      <= snap_d;
                    blink_q     <= blink_d;
                    blink_cnt_q <= blink_cnt_d;
                    ser_data_q  <= word_d[15];
                    shreg_q     <= {word_d[14:0], 1'b0};
                    ser_clk_q   <= 1'b0;
                    div_q       <= {DIV_W{1'b0}};
                    bit_q       <= 4'd15;
                    state_q     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= {DIV_W{1'b0}};
                        if (!ser_clk_q) begin
                            ser_clk_q <= 1'b1;
                        end else begin
                            // Falling edge: next bit goes out, or the word is done.
                            ser_clk_q <= 1'b0;
                            if (bit_q == 4'd0) begin
                                ser_latch_q <= 1'b1;
                                state_q     <= ST_LATCH;
                            end else begin
                                bit_q      <= bit_q - 4'd1;
                                ser_data_q <= shreg_q[15];
                                shreg_q    <= {shreg_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (div_q == DIV_LAST) begin
                        div_q        <= {DIV_W{1'b0}};
                        ser_latch_q  <= 1'b0;
                        out_en_n_q   <= 1'b0;
                        hold_q       <= {HOLD_W{1'b0}};
                        frame_done_q <= HOLD_ONE && (row_q == 3'd7);
                        state_q      <= ST_HOLD;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        row_q   <= row_q + 3'd1;
                        state_q <= ST_LOAD;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                        // Raise frameDone so it is high exactly on the exit cycle.
                        frame_done_q <= (row_q == 3'd7) && (hold_q == HOLD_PRE);
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign serData   = ser_data_q;
    assign serClk    = ser_clk_q;
    assign serLatch  = ser_latch_q;
    assign outEn_n   = out_en_n_q;
    assign rowIdx    = row_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// -----------------------------------------------------------------------------
// Testbench for led_matrix_scan_driver. The reference model works from the
// scan schedule: the row period is fixed, so each row-load edge is known
// relative to reset release. At each of those edges the model pushes the word
// a 595 should capture and the cycle at which the latch should appear. A
// separate monitor runs a 595 model and serial timing checks on the opposite
// clock edge, and pops the expectations as latches occur.
// -----------------------------------------------------------------------------
module tb_led_matrix_scan_driver;

    localparam int CD      = 3;
    localparam int RH      = 10;
    localparam int BF      = 2;
    localparam int RP      = 1 + 33 * CD + RH;
    localparam int BUDGET  = 5000;

    typedef struct {
        logic [15:0] word;
        int          edge_no;
        int          row;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstBtn;
    logic [63:0] frame;
    logic        eog;
    logic        serData, serClk, serLatch, outEn_n, frameDone;
    logic [2:0]  rowIdx;

    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    bit   have_rst = 1'b0;
    bit   rst_at_edge = 1'b0;
    bit   model_on = 1'b1;
    int   r_edge = 0;
    exp_t exp_q[$];
    int   fd_q[$];

    always #5 clk = ~clk;

    led_matrix_scan_driver #(
        .CLK_DIV(CD), .ROW_HOLD(RH), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rstBtn(rstBtn), .frame(frame), .eog(eog),
        .serData(serData), .serClk(serClk), .serLatch(serLatch),
        .outEn_n(outEn_n), .rowIdx(rowIdx), .frameDone(frameDone)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Reference model: schedule-driven expectations, pushed at each row load.
    int          rel, row, eog_frames;
    logic [63:0] snap;
    bit          blink;
    exp_t        e_new;
    initial begin
        eog_frames = 0;
        snap = 64'd0;
        blink = 1'b1;
        forever begin
            @(posedge clk);
            cyc_n++;
            if (rstBtn === 1'b1) begin
                rst_at_edge = 1'b1;
                have_rst = 1'b1;
                r_edge = cyc_n;
                exp_q.delete();
                fd_q.delete();
                eog_frames = 0;
            end else begin
                rst_at_edge = 1'b0;
                rel = cyc_n - r_edge;
                if (have_rst && model_on && rel >= 1 && ((rel - 1) % RP) == 0) begin
                    row = ((rel - 1) / RP) % 8;
                    if (row == 0) begin
                        snap = frame;
                        if (eog) begin
                            blink = ((eog_frames / BF) % 2) == 0;
                            eog_frames++;
                        end else begin
                            blink = 1'b1;
                            eog_frames = 0;
                        end
                    end
                    e_new.word    = {8'(1 << row), blink ? ~snap[8*row +: 8] : 8'hFF};
                    e_new.edge_no = cyc_n + 32 * CD;
                    e_new.row     = row;
                    exp_q.push_back(e_new);
                    if (row == 7) fd_q.push_back(cyc_n + RP - 2);
                end
            end
        end
    end

    // Monitor: 595 model, serial timing, latch and frameDone checks.
    initial begin : monitor
        bit          p_clk, p_dat, p_lat, oe_armed;
        int          hi_len, lo_len, bits, lat_len, fe;
        logic [15:0] sr;
        exp_t        e;
        p_clk = 0; p_dat = 0; p_lat = 0; oe_armed = 0;
        hi_len = 0; lo_len = 0; bits = 0; lat_len = 0; sr = 16'd0;
        forever begin
            @(negedge clk);
            if (!have_rst) continue;
            if (rst_at_edge) begin
                p_clk = 0; p_dat = 0; p_lat = 0; oe_armed = 0;
                hi_len = 0; lo_len = 0; bits = 0; lat_len = 0; sr = 16'd0;
                chk("oe_in_reset", outEn_n, 1);
                continue;
            end
            if (serClk && !p_clk) begin
                chk("data_stable_at_rise", serData, p_dat);
                if (bits > 0) chk("clk_low_len", lo_len, CD);
                sr = {sr[14:0], serData};
                bits++;
                hi_len = 1;
            end else if (serClk) begin
                hi_len++;
            end else if (p_clk) begin
                chk("clk_high_len", hi_len, CD);
                lo_len = 1;
            end else begin
                lo_len++;
            end
            if (serLatch && !p_lat) begin
                if (exp_q.size() == 0) begin
                    if (model_on) chk("latch_unexpected", serLatch, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latch_time", cyc_n, e.edge_no);
                    chk("latch_word", sr, e.word);
                    chk("latch_bits", bits, 16);
                    chk("latch_row", rowIdx, e.row);
                end
                bits = 0;
                lat_len = 1;
            end else if (serLatch) begin
                lat_len++;
            end else if (p_lat) begin
                chk("latch_width", lat_len, CD);
                oe_armed = 1;
            end
            chk("outEn_n", outEn_n, !oe_armed);
            if (frameDone) begin
                if (fd_q.size() == 0) begin
                    if (model_on) chk("frameDone_unexpected", frameDone, 0);
                end else begin
                    fe = fd_q.pop_front();
                    chk("frameDone_time", cyc_n, fe);
                    chk("frameDone_row", rowIdx, 7);
                end
            end
            p_clk = serClk; p_dat = serData; p_lat = serLatch;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int sel, input logic [2:0] v);
        case (sel)
            0: return rowIdx == v;
            1: return serClk;
            2: return serLatch;
            3: return !serLatch;
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic [2:0] v, input string what);
        int n;
        n = 0;
        while (!probe(sel, v) && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!probe(sel, v)) begin
            errors++;
            $display("FAIL wait_%s: condition not seen within %0d cycles", what, BUDGET);
        end
    endtask

    task automatic check_reset();
        chk("rst_serData", serData, 0);
        chk("rst_serClk", serClk, 0);
        chk("rst_serLatch", serLatch, 0);
        chk("rst_outEn_n", outEn_n, 1);
        chk("rst_rowIdx", rowIdx, 0);
        chk("rst_frameDone", frameDone, 0);
    endtask

    task automatic apply_reset();
        rstBtn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset();
        end
        rstBtn = 1'b0;
    endtask

    function automatic logic [63:0] inc_frame();
        logic [63:0] f;
        for (int r = 0; r < 8; r++) f[8*r +: 8] = 8'(r + 1);
        return f;
    endfunction

    // Stimulus
    initial begin
        int n, missed;
        rstBtn = 1'b1;
        eog    = 1'b0;
        frame  = 64'h0000_0000_0000_0080;
        apply_reset();
        wait_cycles(2 * 8 * RP);

        frame = inc_frame();
        wait_cycles(2 * 8 * RP);

        frame[47:40] = 8'hFF;
        wait_for(0, 3'd7, "row7");
        wait_for(0, 3'd0, "row0");
        wait_for(0, 3'd2, "row2");
        wait_for(2, 3'd0, "latch_high");
        wait_for(3, 3'd0, "latch_low");
        frame[47:40] = 8'h00;
        wait_cycles(2 * 8 * RP);

        for (int i = 0; i < 12; i++) begin
            wait_cycles($urandom_range(40, 900));
            frame = {$urandom, $urandom};
            eog   = ($urandom_range(0, 3) == 0);
        end
        eog = 1'b0;
        wait_cycles(8 * RP);

        wait_for(1, 3'd0, "serClk_high");
        frame = {64{1'b1}};
        eog   = 1'b1;
        apply_reset();
        wait_cycles(7 * 8 * RP);
        eog = 1'b0;
        wait_cycles(2 * 8 * RP);

        model_on = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_latches", exp_q.size(), 0);
        missed = 0;
        foreach (fd_q[k]) if (fd_q[k] < cyc_n) missed++;
        chk("frameDone_missing", missed, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
